mem_bus_arb: RTL and testbench
==============================

MEM_BUS_ARB -- requirements
Module: mem_bus_arb

Interface
REQ-001 Parameter DMA_REG_ADDR, default 16'h4014, the CPU write address that triggers OAM DMA.
REQ-002 Parameter OAM_BYTES, default 256, the number of bytes per DMA transfer (power of two, max 256).
REQ-003 clk  in  1  single system clock (25 MHz); all logic rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 sys_req  in  1  sys ctrl (UART loader) requests bus ownership.
REQ-006 sys_gnt  out  1  sys ctrl owns the bus.
REQ-007 sys_addr / sys_wdata / sys_we / sys_re  in  16/8/1/1  sys ctrl bus.
REQ-008 cpu_addr / cpu_wdata / cpu_we / cpu_re  in  16/8/1/1  6502 bus.
REQ-009 cpu_stall  out  1  CPU halt; high whenever the CPU does not own the bus.
REQ-010 mem_addr / mem_wdata / mem_we / mem_re  out  16/8/1/1  to mem ctrl.
REQ-011 mem_rdata  in  8  mem ctrl read data, valid the cycle after mem_re.
REQ-012 spram_addr / spram_wdata / spram_we  out  8/8/1  sprite RAM write port.
REQ-013 dma_busy  out  1  high in DMA_RD or DMA_WR.

Function
REQ-014 States: CPU, SYS, DMA_RD, DMA_WR; the mem_* outputs mux the CPU bus in CPU, the sys bus in SYS, and the DMA engine in DMA states.
REQ-015 CPU→SYS when sys_req=1 at a clock edge; sys_gnt rises the next cycle, and the sys_we/sys_re of that cycle are driven to mem.
REQ-016 SYS→CPU one cycle after sys_req falls; sys_gnt is low in that cycle.
REQ-017 In CPU state, cpu_we=1 with cpu_addr==DMA_REG_ADDR latches page=cpu_wdata and idx=0, and enters DMA_RD next cycle; the write itself is also forwarded to mem.
REQ-018 DMA_RD: mem_addr={page,idx}, mem_re=1, mem_we=0; next state DMA_WR.
REQ-019 DMA_WR: spram_addr=idx, spram_wdata=mem_rdata, spram_we=1, mem_re=mem_we=0; then idx increments (8-bit wrap).
REQ-020 After the write with idx==OAM_BYTES-1, go to SYS if sys_req=1, else CPU; a transfer takes exactly 2*OAM_BYTES cycles.
REQ-021 Priority: an in-flight DMA always completes; sys_req seen during DMA is serviced immediately after; a DMA trigger is only recognised in CPU state.
REQ-022 cpu_stall=1 in SYS, DMA_RD and DMA_WR; cpu_we/cpu_re are ignored whenever cpu_stall=1.
REQ-023 spram_we=0 in all states other than DMA_WR.
REQ-024 Simultaneous sys_req and a DMA trigger in CPU state: the trigger wins; sys waits per REQ-021.

Reset
REQ-025 rst=1: state=CPU, idx=0, page=0, sys_gnt=0, cpu_stall=0, dma_busy=0, and mem_we, mem_re and spram_we are 0.
REQ-026 rst during DMA aborts it without any further spram write; no state is retained.

Configuration
REQ-027 MEM_BUS_ARB_OAM_DMA_EN defined: DMA engine and DMA states present as specified.
REQ-028 MEM_BUS_ARB_OAM_DMA_EN undefined: no DMA states; writes to DMA_REG_ADDR pass to mem only; spram_we and dma_busy are tied 0.

Structure
REQ-029 Shared package nes_bus_pkg: arb_state_t enum, OAM_DMA_REG constant 16'h4014, bus width constants.
REQ-030 One sub-module, oam_dma_engine (page/idx counters and RD/WR sequencing), instantiated only under the macro.

Verification
REQ-031 CPU write 0x4014←0x02, with memory 0x0200+i=i^0x5A -> spram[i]=i^0x5A for all 256 bytes; dma_busy high exactly 512 cycles; cpu_stall high throughout.
REQ-032 sys_req asserted at DMA cycle 100 -> DMA completes, then sys_gnt=1 the next cycle; no CPU access in between.
REQ-033 sys_req high, sys write 0x8000←0xA9 -> mem_we=1 with mem_addr=0x8000; cpu_we pulses ignored; sys_gnt low one cycle after sys_req falls.
REQ-034 rst pulse at DMA byte 37 -> no spram_we after reset; state=CPU; outputs at reset values.
REQ-035 Macro undefined, CPU write 0x4014←0x03 -> single mem_we, spram_we never 1, cpu_stall stays 0.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared bus definitions for the NES memory-bus slice: widths, the OAM DMA
// register address and the arbiter state encoding.
package nes_bus_pkg;

    localparam int unsigned ADDR_W         = 16;
    localparam int unsigned DATA_W         = 8;
    localparam int unsigned SPRAM_AW       = 8;
    localparam int unsigned OAM_BYTES_MAX  = 256;

    localparam logic [ADDR_W-1:0] OAM_DMA_REG = 16'h4014;

    // Bus owner / DMA phase.
    typedef enum logic [1:0] {
        ST_CPU    = 2'd0,
        ST_SYS    = 2'd1,
        ST_DMA_RD = 2'd2,
        ST_DMA_WR = 2'd3
    } arb_state_t;

    // A CPU write to the DMA register starts an OAM transfer.
    function automatic logic is_dma_trigger(
        input logic              we,
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] reg_addr
    );
        return we && (addr == reg_addr);
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: holds the source page and byte index, forms the memory
// read address and the sprite-RAM write port. Phase sequencing (read/write)
// is driven by the arbiter through load/advance.
// Only instantiated when MEM_BUS_ARB_OAM_DMA_EN is defined.
module oam_dma_engine
    import nes_bus_pkg::*;
#(
    parameter int unsigned OAM_BYTES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [DATA_W-1:0]   load_page,
    input  logic                advance,
    input  logic [DATA_W-1:0]   rd_data,
    output logic [ADDR_W-1:0]   dma_addr,
    output logic [SPRAM_AW-1:0] spram_addr,
    output logic [DATA_W-1:0]   spram_wdata,
    output logic                last
);

    localparam logic [SPRAM_AW-1:0] LAST_IDX = SPRAM_AW'(OAM_BYTES - 1);

    logic [DATA_W-1:0]   page;
    logic [SPRAM_AW-1:0] idx;

    // Page/index counters: load on trigger, step after each sprite write.
    always_ff @(posedge clk) begin
        if (rst) begin
            page <= '0;
            idx  <= '0;
        end else if (load) begin
            page <= load_page;
            idx  <= '0;
        end else if (advance) begin
            idx <= idx + SPRAM_AW'(1);
        end
    end

    assign dma_addr    = {page, idx};
    assign spram_addr  = idx;
    assign spram_wdata = rd_data;
    assign last        = (idx == LAST_IDX);

endmodule

// File: rtl/mem_bus_arb.sv
// Memory bus arbiter: muxes the 6502 bus, the system controller (UART
// loader) bus and the OAM DMA engine onto the memory controller port.
// Optional feature macro: MEM_BUS_ARB_OAM_DMA_EN (OAM DMA engine present).
module mem_bus_arb
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = OAM_DMA_REG,
    parameter int unsigned OAM_BYTES    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sys_req,
    output logic        sys_gnt,
    input  logic [15:0] sys_addr,
    input  logic [7:0]  sys_wdata,
    input  logic        sys_we,
    input  logic        sys_re,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic        cpu_stall,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  spram_addr,
    output logic [7:0]  spram_wdata,
    output logic        spram_we,
    output logic        dma_busy
);

    arb_state_t state;
    arb_state_t state_nxt;

`ifdef MEM_BUS_ARB_OAM_DMA_EN
    logic        dma_trig;
    logic        dma_load;
    logic        dma_adv;
    logic        dma_last;
    logic [15:0] dma_addr;

    assign dma_trig = is_dma_trigger(cpu_we, cpu_addr, DMA_REG_ADDR);
    assign dma_load = (state == ST_CPU) && dma_trig;
    assign dma_adv  = (state == ST_DMA_WR);

    oam_dma_engine #(
        .OAM_BYTES (OAM_BYTES)
    ) u_dma (
        .clk         (clk),
        .rst         (rst),
        .load        (dma_load),
        .load_page   (cpu_wdata),
        .advance     (dma_adv),
        .rd_data     (mem_rdata),
        .dma_addr    (dma_addr),
        .spram_addr  (spram_addr),
        .spram_wdata (spram_wdata),
        .last        (dma_last)
    );
`else
    logic unused_cfg;

    assign unused_cfg  = ^{mem_rdata, DMA_REG_ADDR, OAM_BYTES};
    assign spram_addr  = '0;
    assign spram_wdata = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CPU;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: sys ownership follows sys_req; a DMA runs to completion.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CPU: begin
                if (sys_req) begin
                    state_nxt = ST_SYS;
                end
`ifdef MEM_BUS_ARB_OAM_DMA_EN
                // A trigger outranks a simultaneous sys_req; sys is served after.
                if (dma_trig) begin
                    state_nxt = ST_DMA_RD;
                end
`endif
            end
            ST_SYS: begin
                if (!sys_req) begin
                    state_nxt = ST_CPU;
                end
            end
`ifdef MEM_BUS_ARB_OAM_DMA_EN
            ST_DMA_RD: begin
                state_nxt = ST_DMA_WR;
            end
            ST_DMA_WR: begin
                if (dma_last) begin
                    state_nxt = sys_req ? ST_SYS : ST_CPU;
                end else begin
                    state_nxt = ST_DMA_RD;
                end
            end
`endif
            default: begin
                state_nxt = ST_CPU;
            end
        endcase
    end

    // Output mux and handshakes; rst forces all strobes and flags low at once.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        mem_re    = cpu_re;
        sys_gnt   = 1'b0;
        cpu_stall = 1'b0;
        dma_busy  = 1'b0;
        spram_we  = 1'b0;
        case (state)
            ST_CPU: begin
            end
            ST_SYS: begin
                mem_addr  = sys_addr;
                mem_wdata = sys_wdata;
                mem_we    = sys_we;
                mem_re    = sys_re;
                sys_gnt   = 1'b1;
                cpu_stall = 1'b1;
            end
`ifdef MEM_BUS_ARB_OAM_DMA_EN
            ST_DMA_RD: begin
                mem_addr  = dma_addr;
                mem_wdata = '0;
                mem_we    = 1'b0;
                mem_re    = 1'b1;
                cpu_stall = 1'b1;
                dma_busy  = 1'b1;
            end
            ST_DMA_WR: begin
                mem_addr  = dma_addr;
                mem_wdata = '0;
                mem_we    = 1'b0;
                mem_re    = 1'b0;
                spram_we  = 1'b1;
                cpu_stall = 1'b1;
                dma_busy  = 1'b1;
            end
`endif
            default: begin
                mem_we    = 1'b0;
                mem_re    = 1'b0;
                cpu_stall = 1'b1;
            end
        endcase
        if (rst) begin
            mem_we    = 1'b0;
            mem_re    = 1'b0;
            spram_we  = 1'b0;
            sys_gnt   = 1'b0;
            cpu_stall = 1'b0;
            dma_busy  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_bus_arb.sv
// Bench for mem_bus_arb: ownership-level reference model (owner flag and a
// DMA cycle countdown), memory contents given by a formula of the address.
module tb_mem_bus_arb;

    localparam int N = 256;
`ifdef MEM_BUS_ARB_OAM_DMA_EN
    localparam bit DMA_EN = 1'b1;
`else
    localparam bit DMA_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sys_req, sys_gnt, sys_we, sys_re;
    logic [15:0] sys_addr;
    logic [7:0]  sys_wdata;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we, cpu_re, cpu_stall;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic [7:0]  spram_addr, spram_wdata;
    logic        spram_we, dma_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int sp_writes = 0;
    logic [7:0] spram_img [0:255];

    // Model state: sys owns the bus, DMA cycles remaining, DMA page.
    bit         m_sys;
    int         m_left;
    logic [7:0] m_page;
    logic [45:0] exp_vec, exp_mask, obs;

    assign obs = {sys_gnt, cpu_stall, dma_busy, mem_we, mem_re, spram_we,
                  mem_addr, mem_wdata, spram_addr, spram_wdata};

    mem_bus_arb #(
        .DMA_REG_ADDR (16'h4014),
        .OAM_BYTES    (N)
    ) dut (
        .clk (clk), .rst (rst),
        .sys_req (sys_req), .sys_gnt (sys_gnt),
        .sys_addr (sys_addr), .sys_wdata (sys_wdata), .sys_we (sys_we), .sys_re (sys_re),
        .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata), .cpu_we (cpu_we), .cpu_re (cpu_re),
        .cpu_stall (cpu_stall),
        .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_we (mem_we), .mem_re (mem_re),
        .mem_rdata (mem_rdata),
        .spram_addr (spram_addr), .spram_wdata (spram_wdata), .spram_we (spram_we),
        .dma_busy (dma_busy)
    );

    always #20 clk = ~clk;

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'h02);
    endfunction

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem_fn(mem_addr);
        if (spram_we) begin
            spram_img[spram_addr] <= spram_wdata;
            sp_writes <= sp_writes + 1;
        end
    end

    task automatic model_eval();
        int k, b;
        exp_vec  = '0;
        exp_mask = {6'h3F, 40'd0};
        if (rst) begin
            exp_vec = '0;
        end else if (m_left > 0) begin
            k = 2 * N - m_left;
            b = k / 2;
            if (k % 2 == 0) begin
                exp_vec[45:40]  = 6'b011010;
                exp_vec[39:24]  = {m_page, b[7:0]};
                exp_mask[39:24] = '1;
            end else begin
                exp_vec[45:40] = 6'b011001;
                exp_vec[15:8]  = b[7:0];
                exp_vec[7:0]   = mem_fn({m_page, b[7:0]});
                exp_mask[15:0] = '1;
            end
        end else if (m_sys) begin
            exp_vec[45:40]  = {1'b1, 1'b1, 1'b0, sys_we, sys_re, 1'b0};
            exp_vec[39:16]  = {sys_addr, sys_wdata};
            exp_mask[39:16] = '1;
        end else begin
            exp_vec[45:40]  = {1'b0, 1'b0, 1'b0, cpu_we, cpu_re, 1'b0};
            exp_vec[39:16]  = {cpu_addr, cpu_wdata};
            exp_mask[39:16] = '1;
        end
    endtask

    task automatic model_advance();
        if (rst) begin
            m_left = 0; m_sys = 1'b0; m_page = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_sys = sys_req;
        end else if (m_sys) begin
            m_sys = sys_req;
        end else if (DMA_EN && cpu_we && cpu_addr == 16'h4014) begin
            m_left = 2 * N;
            m_page = cpu_wdata;
        end else begin
            m_sys = sys_req;
        end
    endtask

    task automatic cpu_idle();
        cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    endtask

    task automatic sys_idle();
        sys_we = 1'b0; sys_re = 1'b0; sys_addr = 16'h0000; sys_wdata = 8'h00;
    endtask

    task automatic cpu_rand_safe();
        cpu_we = 1'($urandom); cpu_re = 1'($urandom);
        cpu_addr = 16'h8000 | 16'($urandom); cpu_wdata = 8'($urandom);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rst = (c < 3);
            cpu_rand_safe(); cpu_re = 1'b1;
            sys_req = 1'b0; sys_idle();
            #1; model_eval();
            n_tests++;
            if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin
                n_fail++;
                $display("FAIL reset c=%0d got=%h exp=%h mask=%h", c, obs, exp_vec, exp_mask);
            end
            model_advance();
        end
    endtask

    task automatic test_cpu_passthru();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rst = 1'b0; sys_req = 1'b0;
            cpu_rand_safe();
            sys_we = 1'($urandom); sys_re = 1'($urandom);
            sys_addr = 16'($urandom); sys_wdata = 8'($urandom);
            #1; model_eval();
            n_tests++;
            if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin
                n_fail++;
                $display("FAIL cpu_passthru c=%0d got=%h exp=%h mask=%h", c, obs, exp_vec, exp_mask);
            end
            model_advance();
        end
    endtask

    task automatic test_sys_owner();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            rst = 1'b0;
            sys_req = (c <= 5);
            if (c == 1) begin
                sys_we = 1'b1; sys_re = 1'b0; sys_addr = 16'h8000; sys_wdata = 8'hA9;
            end else begin
                sys_we = 1'b0; sys_re = 1'($urandom);
                sys_addr = 16'($urandom); sys_wdata = 8'($urandom);
            end
            if (c >= 1 && c <= 6) begin
                cpu_we = c[0]; cpu_re = 1'($urandom);
                cpu_addr = (c == 3) ? 16'h4014 : 16'($urandom);
                cpu_wdata = 8'($urandom);
            end else begin
                cpu_idle();
            end
            #1; model_eval();
            n_tests++;
            if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin
                n_fail++;
                $display("FAIL sys_owner c=%0d got=%h exp=%h mask=%h", c, obs, exp_vec, exp_mask);
            end
            if (c == 1) begin
                n_tests++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h8000, 8'hA9}) begin
                    n_fail++;
                    $display("FAIL sys_write got=%h exp=%h", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h8000, 8'hA9});
                end
            end
            if (c == 3) begin
                n_tests++;
                if ({sys_gnt, cpu_stall, dma_busy} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL sys_stall got=%b exp=110", {sys_gnt, cpu_stall, dma_busy});
                end
            end
            if (c == 7) begin
                n_tests++;
                if (sys_gnt !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sys_release got=%b exp=0", sys_gnt);
                end
            end
            model_advance();
        end
    endtask

`ifdef MEM_BUS_ARB_OAM_DMA_EN
    task automatic test_dma_full();
        int busy_cnt  = 0;
        int stall_low = 0;
        logic [7:0] ei;
        for (int c = 0; c <= 520; c++) begin
            @(negedge clk);
            rst = 1'b0; sys_req = 1'b0; sys_idle();
            if (c == 0) begin
                cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'h02;
            end else if (c <= 512) begin
                cpu_we = 1'($urandom); cpu_re = 1'($urandom);
                cpu_addr = ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom);
                cpu_wdata = 8'($urandom);
            end else begin
                cpu_idle();
            end
            #1; model_eval();
            n_tests++;
            if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin
                n_fail++;
                $display("FAIL dma_full c=%0d got=%h exp=%h mask=%h", c, obs, exp_vec, exp_mask);
            end
            if (dma_busy) busy_cnt++;
            if (c >= 1 && c <= 512 && !cpu_stall) stall_low++;
            model_advance();
        end
        n_tests++;
        if (busy_cnt !== 2 * N) begin
            n_fail++;
            $display("FAIL dma_busy_len got=%0d exp=%0d", busy_cnt, 2 * N);
        end
        n_tests++;
        if (stall_low !== 0) begin
            n_fail++;
            $display("FAIL dma_stall_low got=%0d exp=0", stall_low);
        end
        for (int i = 0; i < N; i++) begin
            ei = 8'(i) ^ 8'h5A;
            n_tests++;
            if (spram_img[i] !== ei) begin
                n_fail++;
                $display("FAIL spram_content i=%0d got=%h exp=%h", i, spram_img[i], ei);
            end
        end
    endtask

    task automatic test_dma_sys();
        int gnt_cycle = -1;
        for (int c = 0; c <= 530; c++) begin
            @(negedge clk);
            rst = 1'b0;
            sys_req = (c >= 101 && c < 525);
            sys_we = 1'($urandom); sys_re = 1'($urandom);
            sys_addr = 16'($urandom); sys_wdata = 8'($urandom);
            if (c == 0) begin
                cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'($urandom);
            end else if (c <= 512) begin
                cpu_rand_safe();
            end else begin
                cpu_idle();
            end
            #1; model_eval();
            n_tests++;
            if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin
                n_fail++;
                $display("FAIL dma_sys c=%0d got=%h exp=%h mask=%h", c, obs, exp_vec, exp_mask);
            end
            if (sys_gnt && gnt_cycle < 0) gnt_cycle = c;
            model_advance();
        end
        n_tests++;
        if (gnt_cycle !== 2 * N + 1) begin
            n_fail++;
            $display("FAIL dma_then_sys gnt_cycle got=%0d exp=%0d", gnt_cycle, 2 * N + 1);
        end
    endtask

    task automatic test_dma_reset();
        int snap = 0;
        int late_we = 0;
        for (int c = 0; c <= 120; c++) begin
            @(negedge clk);
            rst = (c == 75);
            sys_req = 1'b0; sys_idle();
            if (c == 0) begin
                cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'h02;
                snap = sp_writes;
            end else begin
                cpu_rand_safe();
            end
            #1; model_eval();
            n_tests++;
            if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin
                n_fail++;
                $display("FAIL dma_reset c=%0d got=%h exp=%h mask=%h", c, obs, exp_vec, exp_mask);
            end
            if (c >= 75 && spram_we) late_we++;
            if (c == 76) begin
                n_tests++;
                if ({sys_gnt, cpu_stall, dma_busy, spram_we} !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL dma_reset_flags got=%b exp=0000", {sys_gnt, cpu_stall, dma_busy, spram_we});
                end
            end
            model_advance();
        end
        n_tests++;
        if (late_we !== 0) begin
            n_fail++;
            $display("FAIL dma_reset_late_we got=%0d exp=0", late_we);
        end
        n_tests++;
        if (sp_writes - snap !== 37) begin
            n_fail++;
            $display("FAIL dma_reset_writes got=%0d exp=37", sp_writes - snap);
        end
    endtask
`else
    task automatic test_no_dma();
        int we_cnt = 0;
        int sp_cnt = 0;
        int st_cnt = 0;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            rst = 1'b0; sys_req = 1'b0; sys_idle();
            if (c == 0) begin
                cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'h03;
            end else begin
                cpu_idle();
            end
            #1; model_eval();
            n_tests++;
            if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin
                n_fail++;
                $display("FAIL no_dma c=%0d got=%h exp=%h mask=%h", c, obs, exp_vec, exp_mask);
            end
            if (mem_we) we_cnt++;
            if (spram_we) sp_cnt++;
            if (cpu_stall || dma_busy) st_cnt++;
            model_advance();
        end
        n_tests++;
        if ({we_cnt, sp_cnt, st_cnt} !== {32'd1, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL no_dma_counts got we=%0d sp=%0d stall=%0d exp we=1 sp=0 stall=0", we_cnt, sp_cnt, st_cnt);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 19) == 0) sys_req = ~sys_req;
            sys_we = 1'($urandom); sys_re = 1'($urandom);
            sys_addr = 16'($urandom); sys_wdata = 8'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'($urandom);
            end else begin
                cpu_we = 1'($urandom); cpu_re = 1'($urandom);
                cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
            end
            #1; model_eval();
            n_tests++;
            if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin
                n_fail++;
                $display("FAIL random c=%0d got=%h exp=%h mask=%h", c, obs, exp_vec, exp_mask);
            end
            model_advance();
        end
    endtask

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sys_req = 1'b0;
        sys_idle(); cpu_idle();
        m_sys = 1'b0; m_left = 0; m_page = '0;
        test_reset();
        test_cpu_passthru();
        test_sys_owner();
`ifdef MEM_BUS_ARB_OAM_DMA_EN
        test_dma_full();
        test_dma_sys();
        test_dma_reset();
`else
        test_no_dma();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
